int8_mac_unit: RTL and testbench

- Pipelined signed INT8 dot-product MAC for the matrix accelerator datapath.
- Each accepted beat multiplies 33 INT8 lanes of a_vec by the matching 33 lanes of b_vec, sums the 33 products, and adds partial_sum_in.
- Produces a 24-bit partial_sum_out for chaining to the next MAC or accumulator.
- Fully pipelined: one new vector pair per clock, fixed 2-cycle latency.

---
 rtl/int8_mac_unit.sv | 99 +++++++++
 tb/tb_int8_mac_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/int8_mac_unit.sv
// int8_mac_unit: two-stage pipelined signed INT8 dot-product MAC.
//
// Each beat with int8_en high multiplies N_ELEM signed lanes of a_vec by the
// matching lanes of b_vec, sums the products and adds partial_sum_in. The
// result appears on partial_sum_out with out_valid high two clock edges after
// the beat is accepted. A new beat can be accepted every cycle, and there is
// no back-pressure.
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset; clears all pipeline state
//   int8_en         beat enable; inputs are sampled only when high
//   a_vec, b_vec    N_ELEM packed signed lanes, lane k at [k*DATA_W +: DATA_W]
//   partial_sum_in  signed partial sum added to the dot product
//   partial_sum_out registered signed result (wraps modulo 2^ACC_W)
//   out_valid       one-cycle strobe aligned with each new partial_sum_out

module int8_mac_unit #(
    parameter int unsigned N_ELEM = 33,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       int8_en,
    input  logic [N_ELEM*DATA_W-1:0]   a_vec,
    input  logic [N_ELEM*DATA_W-1:0]   b_vec,
    input  logic [ACC_W-1:0]           partial_sum_in,
    output logic [ACC_W-1:0]           partial_sum_out,
    output logic                       out_valid
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    // Wide enough that the sum of N_ELEM full-scale products never overflows.
    localparam int unsigned SUM_W  = PROD_W + $clog2(N_ELEM);

    // Stage 1: lane products, partial sum and valid.
    logic signed [PROD_W-1:0] prod_d [N_ELEM];
    logic signed [PROD_W-1:0] prod_q [N_ELEM];
    logic signed [ACC_W-1:0]  psum_q;
    logic                     vld_q;

    // Stage 2: result register and output strobe.
    logic signed [SUM_W-1:0]  dot_sum;
    logic signed [ACC_W-1:0]  sum_d;
    logic        [ACC_W-1:0]  sum_q;
    logic                     out_vld_q;

    always_comb begin
        for (int unsigned k = 0; k < N_ELEM; k++) begin
            prod_d[k] = PROD_W'($signed(a_vec[k*DATA_W +: DATA_W]))
                      * PROD_W'($signed(b_vec[k*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_ELEM; k++) begin
                prod_q[k] <= '0;
            end
            psum_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= int8_en;
            // Data registers only load on a valid beat; their content is
            // irrelevant while vld_q is low.
            if (int8_en) begin
                prod_q <= prod_d;
                psum_q <= $signed(partial_sum_in);
            end
        end
    end

    // Adder tree over sign-extended products, then a wrapping add of the
    // partial sum at the output width.
    always_comb begin
        dot_sum = '0;
        for (int unsigned k = 0; k < N_ELEM; k++) begin
            dot_sum = dot_sum + SUM_W'(prod_q[k]);
        end
        sum_d = ACC_W'(dot_sum) + psum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= vld_q;
            if (vld_q) begin
                sum_q <= sum_d;
            end
        end
    end

    assign partial_sum_out = sum_q;
    assign out_valid       = out_vld_q;

endmodule

// File: tb/tb_int8_mac_unit.sv
// Scoreboard bench for int8_mac_unit: the driver pushes the expected result
// and its due cycle for every beat; a monitor on the falling edge pops and
// compares, and between results checks that out_valid is low and the output
// holds its last value.

module tb_int8_mac_unit;

    localparam int N = 33;

    logic                clk;
    logic                rst_n;
    logic                int8_en;
    logic [N*8-1:0]      a_vec;
    logic [N*8-1:0]      b_vec;
    logic [23:0]         partial_sum_in;
    logic [23:0]         partial_sum_out;
    logic                out_valid;

    int8_mac_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .int8_en         (int8_en),
        .a_vec           (a_vec),
        .b_vec           (b_vec),
        .partial_sum_in  (partial_sum_in),
        .partial_sum_out (partial_sum_out),
        .out_valid       (out_valid)
    );

    typedef struct {
        logic [23:0] val;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          la[N];
    int          lb[N];
    int          cyc     = 0;
    int          n_vec   = 0;
    int          n_check = 0;
    int          n_fail  = 0;
    logic [23:0] last_out = '0;
    bit          done    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer dot product plus partial sum, low 24 bits.
    function automatic logic [23:0] model(input logic [23:0] ps);
        int s;
        s = int'($signed(ps));
        for (int k = 0; k < N; k++) s += la[k] * lb[k];
        return s[23:0];
    endfunction

    task automatic clear_lanes();
        for (int k = 0; k < N; k++) begin
            la[k] = 0;
            lb[k] = 0;
        end
    endtask

    task automatic send(input logic [23:0] ps);
        exp_t e;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            a_vec[k*8 +: 8] = la[k][7:0];
            b_vec[k*8 +: 8] = lb[k][7:0];
        end
        partial_sum_in = ps;
        int8_en        = 1'b1;
        e.val = model(ps);
        e.due = cyc + 2;
        q.push_back(e);
        n_vec++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            int8_en = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_check++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%06h, expected 0x%06h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: one comparison per cycle while out of reset.
    always @(negedge clk) begin
        if (rst_n && !done) begin
            if (q.size() != 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                check("out_valid on result", {23'd0, out_valid}, 24'd1);
                check("partial_sum_out", partial_sum_out, e.val);
                last_out = e.val;
            end else begin
                check("out_valid idle", {23'd0, out_valid}, 24'd0);
                check("partial_sum_out hold", partial_sum_out, last_out);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        int8_en        = 1'b0;
        a_vec          = '0;
        b_vec          = '0;
        partial_sum_in = '0;
        clear_lanes();
        #2;
        check("reset out", partial_sum_out, 24'd0);
        check("reset valid", {23'd0, out_valid}, 24'd0);
        #10;
        rst_n = 1'b1;

        // Directed corner cases.
        clear_lanes();
        send(24'h000000);                                   // 0
        for (int k = 0; k < N; k++) begin la[k] = 1; lb[k] = 1; end
        send(24'h000000);                                   // 33
        for (int k = 0; k < N; k++) begin la[k] = -128; lb[k] = -128; end
        send(24'h000000);                                   // 0x084000
        for (int k = 0; k < N; k++) begin la[k] = 127; lb[k] = -128; end
        send(24'h000000);                                   // 0xF7D080
        clear_lanes();
        la[32] = -3; lb[32] = 2;
        send(24'h000000);                                   // 0xFFFFFA
        clear_lanes();
        la[0] = 1; lb[0] = 1;
        send(24'h7FFFFF);                                   // wraps to 0x800000
        idle(2);

        // Back-to-back 1, 2, 3 then idle: output must hold 3.
        clear_lanes();
        la[0] = 1;
        for (int v = 1; v <= 3; v++) begin
            lb[0] = v;
            send(24'h000000);
        end
        idle(4);

        // Randomised beats with random idle gaps.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    la[k] = ($urandom_range(0, 1) != 0) ? 127 : -128;
                    lb[k] = ($urandom_range(0, 1) != 0) ? 127 : -128;
                end else begin
                    la[k] = int'($urandom_range(0, 255)) - 128;
                    lb[k] = int'($urandom_range(0, 255)) - 128;
                end
            end
            send(24'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        idle(3);

        // Asynchronous reset with two beats in flight.
        clear_lanes();
        la[5] = 10; lb[5] = 10;
        send(24'h000123);
        la[5] = 20;
        send(24'h000456);
        #2;
        rst_n   = 1'b0;
        int8_en = 1'b0;
        q.delete();
        last_out = '0;
        #1;
        check("async reset out", partial_sum_out, 24'd0);
        check("async reset valid", {23'd0, out_valid}, 24'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle(4);

        // A beat after reset release must still flow normally.
        la[1] = -7; lb[1] = 9;
        send(24'h000010);
        idle(1);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
        idle(1);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
